// File: rtl/stage_writeback.sv
// stage_writeback: final MIPS pipeline stage. Retires instructions from the
// memory stage, waits for multi-cycle load responses, aligns and extends
// load data, and drives the registered register-file write command.
module stage_writeback (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        nullify,
    input  logic        in_write_reg,
    input  logic [4:0]  in_dest_reg,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_rt_data,
    input  logic        in_mem_read,
    input  logic [2:0]  in_load_type,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall_out,
    output logic        write_reg,
    output logic [4:0]  dest_reg,
    output logic [31:0] dest_reg_data,
    output logic        retire_valid,
    output logic [31:0] retire_count
);

    localparam int DATA_W = 32;

    localparam logic [2:0] LT_LW  = 3'd0;
    localparam logic [2:0] LT_LB  = 3'd1;
    localparam logic [2:0] LT_LBU = 3'd2;
    localparam logic [2:0] LT_LH  = 3'd3;
    localparam logic [2:0] LT_LHU = 3'd4;
    localparam logic [2:0] LT_LWL = 3'd5;
    localparam logic [2:0] LT_LWR = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state;

    // Load context captured at accept time, consumed when the response arrives
    logic              ld_write_p0;
    logic [4:0]        ld_dest_p0;
    logic [2:0]        ld_type_p0;
    logic [1:0]        ld_off_p0;
    logic [DATA_W-1:0] ld_rt_p0;

    logic accept_load;

    // Align/extend a little-endian load word; o is the byte offset within it
    function automatic logic [DATA_W-1:0] align_load(
        input logic [2:0]        lt,
        input logic [1:0]        o,
        input logic [DATA_W-1:0] d,
        input logic [DATA_W-1:0] rt
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = d[8*o +: 8];
        h = o[1] ? d[31:16] : d[15:0];
        case (lt)
            LT_LB:   r = {{24{b[7]}}, b};
            LT_LBU:  r = {24'd0, b};
            LT_LH:   r = {{16{h[15]}}, h};
            LT_LHU:  r = {16'd0, h};
            LT_LWL: begin
                case (o)
                    2'd0:    r = {d[7:0],  rt[23:0]};
                    2'd1:    r = {d[15:0], rt[15:0]};
                    2'd2:    r = {d[23:0], rt[7:0]};
                    default: r = d;
                endcase
            end
            LT_LWR: begin
                case (o)
                    2'd0:    r = d;
                    2'd1:    r = {rt[31:24], d[31:8]};
                    2'd2:    r = {rt[31:16], d[31:16]};
                    default: r = {rt[31:8],  d[31:24]};
                endcase
            end
            default: r = d;   // LW and the unused encoding 7
        endcase
        return r;
    endfunction

    assign accept_load = (state == ST_IDLE) && in_valid && !nullify && in_mem_read;
    assign stall_out   = (state != ST_IDLE);

    // Capture load context when a load is accepted
    always_ff @(posedge clk) begin
        if (accept_load) begin
            ld_write_p0 <= in_write_reg;
            ld_dest_p0  <= in_dest_reg;
            ld_type_p0  <= in_load_type;
            ld_off_p0   <= in_alu_result[1:0];
            ld_rt_p0    <= in_rt_data;
        end
    end

    // Control FSM with registered write command and retire counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            write_reg     <= 1'b0;
            retire_valid  <= 1'b0;
            dest_reg      <= 5'd0;
            dest_reg_data <= '0;
            retire_count  <= '0;
        end else begin
            write_reg    <= 1'b0;
            retire_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid && !nullify) begin
                        if (in_mem_read) begin
                            state <= ST_WAIT;
                        end else begin
                            write_reg     <= in_write_reg && (in_dest_reg != 5'd0);
                            retire_valid  <= 1'b1;
                            dest_reg      <= in_dest_reg;
                            dest_reg_data <= in_alu_result;
                            retire_count  <= retire_count + 32'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (nullify) begin
                        // A response arriving with the flush is simply dropped
                        state <= mem_rvalid ? ST_IDLE : ST_DRAIN;
                    end else if (mem_rvalid) begin
                        write_reg     <= ld_write_p0 && (ld_dest_p0 != 5'd0);
                        retire_valid  <= 1'b1;
                        dest_reg      <= ld_dest_p0;
                        dest_reg_data <= align_load(ld_type_p0, ld_off_p0, mem_rdata, ld_rt_p0);
                        retire_count  <= retire_count + 32'd1;
                        state         <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mem_rvalid) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/stage_writeback.md
# stage_writeback

Final pipeline stage of the MIPS core and the writing end of the register-file port the decode stage reads. It takes retiring instructions from the memory stage, waits for a multi-cycle data-memory response on loads, aligns and extends load data, and drives the registered write command (`dest_reg`, `dest_reg_data`, `write_reg`). Decode applies that command to the register file and the forwarder uses it for bypass. It also stalls upstream while a load is outstanding and counts retired instructions.

## Interface
- No parameters. Data width is fixed at 32 and the register address at 5.
- `clk  in  1` — pipeline clock.
- `reset  in  1` — asynchronous, active-low reset.
- `in_valid  in  1` — memory stage presents an instruction.
- `nullify  in  1` — kill the current or pending instruction (exception flush).
- `in_write_reg  in  1` — the instruction writes a GPR.
- `in_dest_reg  in  5` — destination GPR.
- `in_alu_result  in  32` — ALU result, or effective address for loads.
- `in_rt_data  in  32` — old rt value, used to merge LWL/LWR results.
- `in_mem_read  in  1` — the instruction is a load.
- `in_load_type  in  3` — 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LWL, 6 LWR.
- `mem_rvalid  in  1` — data-memory read response is valid this cycle.
- `mem_rdata  in  32` — response word (little-endian).
- `stall_out  out  1` — upstream must hold its instruction.
- `write_reg  out  1` — register-file write enable, one-cycle pulse per commit.
- `dest_reg  out  5` — write address.
- `dest_reg_data  out  32` — write data.
- `retire_valid  out  1` — one-cycle pulse per retired instruction.
- `retire_count  out  32` — retired-instruction counter.

## Operation
- FSM has three states:
  - IDLE: accepts a new instruction.
  - WAIT: one load is outstanding.
  - DRAIN: a nullified load's response is still owed and must be swallowed.
- In IDLE, an accept occurs when `in_valid` is high and `nullify` is low.
  - Non-load: commit next cycle. `dest_reg_data`=`in_alu_result`; `write_reg`=`in_write_reg && in_dest_reg!=0`. State stays IDLE.
  - Load: latch `dest_reg`, `in_write_reg`, `in_load_type`, `addr[1:0]` and `in_rt_data`, then go to WAIT.
- In WAIT:
  - `mem_rvalid` high with `nullify` low: commit the aligned data and go to IDLE.
  - `nullify` high and `mem_rvalid` low: go to DRAIN.
  - `nullify` and `mem_rvalid` high together: discard the data and go to IDLE.
- In DRAIN, `mem_rvalid` causes a return to IDLE with no commit. `in_valid` is ignored.
- `in_valid` is ignored in WAIT and DRAIN.
- In IDLE, `mem_rvalid` is ignored. A response is never expected there.
- Load alignment, with o = latched `addr[1:0]` and d = `mem_rdata`:
  - LW: d.
  - LB/LBU: byte d[8o+7:8o], sign- or zero-extended.
  - LH/LHU: half selected by o[1], sign- or zero-extended. o[0] is ignored; misalignment is trapped upstream.
  - LWL: (d << 8(3−o)) | (rt & low (3−o) bytes).
  - LWR: (d >> 8o) | (rt & high o bytes).
  - Load type 7 is treated as LW.
- Register 0 is never written. A commit to r0 still retires (`retire_valid`=1, `write_reg`=0).
- `retire_count` increments by 1 per commit, wraps from 0xFFFFFFFF to 0, and does not count nullified instructions.
- Reset values: state IDLE; `write_reg`, `retire_valid`, `dest_reg`, `dest_reg_data` and `retire_count` all 0. Reset mid-WAIT or mid-DRAIN returns to IDLE. The memory is reset in the same domain, so no stale response follows.

## Timing
- All outputs except `stall_out` are registered.
- `stall_out` is combinational: `state!=IDLE`.
- Non-load accepted at edge N: `write_reg` and `retire_valid` are high in cycle N+1 only.
- Load accepted at edge N: `stall_out` is high from cycle N+1. With `mem_rvalid` sampled at edge M, the commit appears in cycle M+1 and `stall_out` is low in M+1.
- A new instruction may be accepted at edge M+1 while the previous commit is visible. Back-to-back non-loads commit every cycle.
- With no commit, `write_reg`=0. `dest_reg` and `dest_reg_data` hold their last values.

## Test plan
- Reset, then a non-load with `in_dest_reg`=5 and `in_alu_result`=0x12345678 → next cycle `write_reg`=1, `dest_reg`=5, data 0x12345678; `retire_count`=1.
- LB from address offset 3, response 0x80FF_0000 after 3 cycles → `stall_out` high 3 cycles; commit 0xFFFFFF80. Repeating as LBU → 0x00000080.
- LWL with o=1, d=0xAABBCCDD, rt=0x11223344 → 0xCCDD3344. LWR with o=1 and the same inputs → 0x11AABBCC.
- Non-load with `in_dest_reg`=0 → `write_reg`=0, `retire_valid`=1, count increments.
- Nullify during WAIT, response 2 cycles later → no commit, `stall_out` stays high until that response, count unchanged. Then a load with nullify and rvalid in the same cycle → IDLE next cycle, no commit.
- `reset` asserted mid-WAIT → all outputs 0 immediately, IDLE. Preload count to 0xFFFFFFFF via commits, or force it, then commit → count 0.
